// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, DATA_BITS data bits, optional parity,
// stop bit; sampled only on Ce, result reported as Valid or FrameErr pulse.
module serial_frame_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Ce,
  input  logic                 Din,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 Valid,
  output logic                 FrameErr,
  output logic                 Busy
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DATA_BITS-1:0] sh, sh_n, dout_n;
  logic                 perr, perr_n;
  logic                 valid_n, ferr_n;
  logic [DATA_BITS-1:0] shifted;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      Dout     <= '0;
      perr     <= 1'b0;
      Valid    <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      Dout     <= dout_n;
      perr     <= perr_n;
      Valid    <= valid_n;
      FrameErr <= ferr_n;
    end
  end

  // Bit order decides which end of the register the new bit enters.
  always_comb begin
    if (LSB_FIRST) shifted = {Din, sh[DATA_BITS-1:1]};
    else           shifted = {sh[DATA_BITS-2:0], Din};
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    dout_n  = Dout;
    perr_n  = perr;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    if (Ce) begin
      unique case (state)
        IDLE: begin
          if (!Din) begin
            state_n = DATA;
            cnt_n   = '0;
            perr_n  = 1'b0;
          end
        end
        DATA: begin
          sh_n  = shifted;
          cnt_n = cnt + CW'(1);
          if (cnt == LAST)
            state_n = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          perr_n  = ((^sh) ^ Din) != PARITY_ODD;
          state_n = STOP;
        end
        STOP: begin
          // A low stop bit ends the frame; it never doubles as a start bit.
          state_n = IDLE;
          if (Din && !perr) begin
            dout_n  = sh;
            valid_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: plain 8N1 instance and an
// even-parity instance sharing the line, each with its own enable.
module tb_serial_frame_rx;

  typedef struct {
    logic       err;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ce  = 1'b0;
  logic       sel = 1'b0;
  logic       Din = 1'b1;
  logic       ce0, ce1;
  logic [7:0] dout0, dout1;
  logic       valid0, valid1, ferr0, ferr1, busy0, busy1;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;

  assign ce0 = ce & ~sel;
  assign ce1 = ce & sel;

  serial_frame_rx #(
    .DATA_BITS(8), .LSB_FIRST(1'b1),
    .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) u_plain (
    .CLK(CLK), .RST(RST), .Ce(ce0), .Din(Din),
    .Dout(dout0), .Valid(valid0),
    .FrameErr(ferr0), .Busy(busy0)
  );

  serial_frame_rx #(
    .DATA_BITS(8), .LSB_FIRST(1'b1),
    .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) u_par (
    .CLK(CLK), .RST(RST), .Ce(ce1), .Din(Din),
    .Dout(dout1), .Valid(valid1),
    .FrameErr(ferr1), .Busy(busy1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input string tag, input logic v, input logic fe,
                     input logic [7:0] d, inout exp_t q[$]);
    exp_t e;
    if (v && fe) chk({tag, "_both_pulses"}, 1, 0);
    if (v || fe) begin
      if (q.size() == 0) begin
        chk({tag, "_unexpected_pulse"}, {v, fe}, 0);
      end else begin
        e = q.pop_front();
        chk({tag, "_kind_ferr"}, fe, e.err);
        chk({tag, "_dout"}, d, e.d);
        chk({tag, "_cycle"}, cyc, e.cyc);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      mon("plain", valid0, ferr0, dout0, q0);
      mon("par", valid1, ferr1, dout1, q1);
    end
  end

  // One enabled sample, preceded by gap disabled cycles carrying junk.
  task automatic send(input logic b, input int gap);
    repeat (gap) begin
      @(negedge CLK);
      ce  = 1'b0;
      Din = ~b;
    end
    @(negedge CLK);
    ce  = 1'b1;
    Din = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      ce  = 1'b1;
      Din = 1'b1;
      @(posedge CLK);
      #1;
      chk(sel ? "par_idle_busy" : "plain_idle_busy",
          sel ? busy1 : busy0, 0);
    end
    @(negedge CLK);
    ce = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic stp,
                       input logic pb, input int gap);
    exp_t e;
    logic good;
    send(1'b0, gap);
    chk("busy_after_start", sel ? busy1 : busy0, 1);
    for (int i = 0; i < 8; i++) send(d[i], gap);
    if (sel) send(pb, gap);
    send(stp, gap);
    chk("busy_after_stop", sel ? busy1 : busy0, 0);
    good = stp && (!sel || (((^d) ^ pb) == 1'b0));
    if (sel) begin
      if (good) last1 = d;
      e.d = last1;
    end else begin
      if (good) last0 = d;
      e.d = last0;
    end
    e.err = !good;
    e.cyc = cyc;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_ferr", ferr0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_par_busy", busy1, 0);
    chk("rst_par_dout", dout1, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // basic 0xA5
    sel = 1'b0;
    frame(8'hA5, 1'b1, 1'b0, 0);
    idle(3);

    // async reset mid-frame
    send(1'b0, 0);
    send(1'b1, 0);
    send(1'b0, 0);
    send(1'b1, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_busy", busy0, 0);
    chk("midrst_valid", valid0, 0);
    chk("midrst_ferr", ferr0, 0);
    chk("midrst_dout", dout0, 0);
    last0 = 8'h00;
    @(negedge CLK);
    ce = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    frame(8'h5A, 1'b1, 1'b0, 0);
    idle(2);

    // sparse enable
    frame(8'hA5, 1'b1, 1'b0, 3);
    idle(2);

    // bad stop after good 0xA5
    frame(8'hFF, 1'b0, 1'b0, 0);
    idle(4);

    // back-to-back
    frame(8'h3C, 1'b1, 1'b0, 0);
    frame(8'hC3, 1'b1, 1'b0, 0);
    idle(2);

    // even parity instance
    sel = 1'b1;
    frame(8'h07, 1'b1, 1'b1, 0);
    idle(2);
    frame(8'h07, 1'b1, 1'b0, 0);
    idle(2);
    frame(8'h81, 1'b1, 1'b0, 1);
    idle(3);

    chk("plain_queue_drained", q0.size(), 0);
    chk("par_queue_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Framed serial receiver that consumes the 1-bit registered bitstream produced by the clock-enabled D-register stage (its Qout drives Din here).
- Shares that stage's Ce, so bits are sampled only on enabled cycles.
- Detects a start bit, shifts in DATA_BITS data bits, optionally checks a parity bit, then checks a stop bit.
- Presents the assembled word with a one-cycle Valid pulse, or a one-cycle FrameErr pulse.

Parameters:
DATA_BITS, 8, number of data bits per frame (2..16)
LSB_FIRST, 1, 1 = first data bit received is bit 0; 0 = first data bit received is bit DATA_BITS-1
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
CLK  input  1  single system clock, rising edge
RST  input  1  asynchronous, active-high reset
Ce  input  1  sample enable; the same enable that drives the upstream D-register
Din  input  1  serial line from the upstream register's Qout; idle level 1
Dout  output  DATA_BITS  last correctly received word
Valid  output  1  one-CLK pulse: Dout updated with a good frame
FrameErr  output  1  one-CLK pulse: bad stop bit or parity mismatch
Busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Interface fixed: one clock CLK; RST is asynchronous and active-high.
- While RST=1, with no clock required:
  - state=IDLE, bit counter=0, shift register=0.
  - Dout=0, Valid=0, FrameErr=0, Busy=0.
- RST asserted mid-frame discards the partial frame; no Valid or FrameErr pulse follows.
- All state changes occur on rising CLK with Ce=1. When Ce=0:
  - state, counter, shift register and Dout hold.
  - Din is ignored.
  - Valid and FrameErr are 0, so pulses are exactly one CLK wide regardless of Ce spacing.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: Ce=1 and Din=0 (start bit) -> DATA, counter=0. Ce=1 and Din=1 -> stay in IDLE.
  - DATA: each Ce=1 shifts Din in.
    - LSB_FIRST=1: shift right, new bit enters the MSB.
    - LSB_FIRST=0: shift left, new bit enters the LSB.
    - Counter increments each shift. The shift with counter==DATA_BITS-1 moves to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: on Ce=1, latch a parity-error flag and go to STOP.
    - Error when (XOR of data bits XOR Din) != PARITY_ODD.
  - STOP: on Ce=1, always go to IDLE.
    - Din=1 and no parity error: Dout <= shift register, Valid=1 for the following CLK cycle.
    - Otherwise: FrameErr=1 for the following CLK cycle, Dout unchanged.
    - A 0 sampled as the stop bit is never reinterpreted as a start bit.
- Frame length is 1+DATA_BITS+PARITY_EN+1 Ce samples. Valid/FrameErr are registered and assert in the CLK cycle right after the edge that sampled the stop bit.
- Back-to-back frames are allowed. A start bit on the first Ce sample after the stop sample is accepted, with no idle bit required.
- Busy=1 from the edge that accepts the start bit through the edge that samples the stop bit (inclusive), then 0.
- Valid and FrameErr are never high together.
- Dout changes only with Valid.

Test Plan:
- Reset: Ce=1 each cycle; raise RST asynchronously between edges after 4 bits of a frame -> Busy, Valid, FrameErr, Dout go to 0 immediately. A following clean frame 0x5A -> Valid with Dout=0x5A.
- Basic frame, defaults, Ce=1 every cycle: Din = 0 | 1,0,1,0,0,1,0,1 | 1 -> exactly one Valid pulse, one cycle after the 10th sampling edge, with Dout=0xA5. Busy high for the 10 sampling edges. FrameErr stays 0.
- Sparse enable: Ce=1 on every 4th CLK, same bit sequence held across gaps, opposite values driven on Ce=0 cycles -> Dout=0xA5. Valid high for exactly one CLK. Opposite values ignored.
- Bad stop bit, after a good 0xA5: frame with data 0xFF and stop=0 -> FrameErr one cycle, Valid 0, Dout stays 0xA5. Busy drops. Next Din=1 samples keep IDLE.
- Back-to-back: frames 0x3C then 0xC3 with no idle bits -> two Valid pulses exactly 10 Ce samples apart, Dout=0x3C then 0xC3.
- Parity, PARITY_EN=1, PARITY_ODD=0: data 0x07 with parity bit 1, stop 1 -> Valid, Dout=0x07. Same data with parity bit 0 -> FrameErr, Dout stays 0x07.
